// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // An access faults when it is not word aligned or its word index lies past the array.
  function automatic logic isFault(input logic [WORD_W-1:0] addr, input int unsigned depthWords);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depthWords);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; the read port only updates on a read access
// so the last loaded word stays visible between accesses.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic                           en_i,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [WORD_W-1:0]              wdata_i,
  output logic [WORD_W-1:0]              rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  // One access per enabled edge: either write the word or capture it on the read port.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one word access, stalls the pipeline
// for LATENCY cycles, then acknowledges for one cycle with load data or a fault flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              ack_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              loadOk_q, loadOk_d;

  logic              enterResp;
  logic              accWe;
  logic [WORD_W-1:0] accAddr;
  logic [WORD_W-1:0] accWdata;
  logic              accFault;
  logic              ramEn;
  logic [WORD_W-1:0] ramRdata;

  // Next-state, stall/ack and the access that lands on the edge entering RESP.
  // With LATENCY = 1 that edge is also the acceptance edge, so the access uses the live inputs.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    loadOk_d  = loadOk_q;
    enterResp = 1'b0;
    stall_o   = 1'b0;
    ack_o     = 1'b0;
    accWe     = we_q;
    accAddr   = addr_q;
    accWdata  = wdata_q;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          stall_o  = 1'b1;
          we_d     = we_i;
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          count_d  = CNT_LOAD;
          accWe    = we_i;
          accAddr  = addr_i;
          accWdata = wdata_i;
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d   = RESP;
            enterResp = 1'b1;
          end
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d   = RESP;
          enterResp = 1'b1;
        end
      end
      RESP: begin
        ack_o   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    accFault = isFault(accAddr, DEPTH_WORDS);
    if (enterResp) begin
      err_d    = accFault;
      loadOk_d = !accFault && !accWe;
    end
  end

  // Faulted accesses never touch the array, and a reset edge suppresses any pending write.
  assign ramEn = enterResp && !accFault && rst_i;

  // State, counter, latched request and response flags with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      loadOk_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      loadOk_q <= loadOk_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk_i),
    .en_i   (ramEn),
    .we_i   (accWe),
    .addr_i (accAddr[AW+1:2]),
    .wdata_i(accWdata),
    .rdata_o(ramRdata)
  );

  // The RAM read port holds its last loaded word; stores, faults and reset present zero.
  assign rdata_o = loadOk_q ? ramRdata : '0;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance 0 uses LATENCY 4 / 1024 words,
// instance 1 uses LATENCY 1 / 16 words.
module tb_dmem_responder;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;
  localparam int DEP0 = 1024;
  localparam int DEP1 = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        stall [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  exp_t expQ0[$];
  exp_t expQ1[$];
  int   nCompared   = 0;
  int   nMismatched = 0;
  int   cycleCnt    = 0;

  dmem_responder #(.DEPTH_WORDS(DEP0), .LATENCY(LAT0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .stall_o(stall[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEP1), .LATENCY(LAT1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .stall_o(stall[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1])
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index used to time acknowledges
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one access, queue its expected response and check stall every cycle up to RESP.
  // keepReq leaves req high through RESP; inResp means the call starts during the previous RESP.
  task automatic applyStimulus(input int inst, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] expR, input logic expE,
                               input string nm, input bit keepReq, input bit inResp,
                               input bit perturb);
    int   lat;
    int   c;
    exp_t e;
    lat         = (inst == 0) ? LAT0 : LAT1;
    req[inst]   = 1'b1;
    we[inst]    = w;
    addr[inst]  = a;
    wdata[inst] = d;
    if (inResp) begin
      #1 checkOutput({nm, "_stall_in_resp"}, 32'(stall[inst]), 32'd0);
      @(negedge clk);
    end
    c       = cycleCnt;
    e.rdata = expR;
    e.err   = expE;
    e.due   = c + lat;
    e.name  = nm;
    if (inst == 0) expQ0.push_back(e);
    else expQ1.push_back(e);
    #1 checkOutput({nm, "_stall_req"}, 32'(stall[inst]), 32'd1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (!keepReq) req[inst] = 1'b0;
      if (perturb) begin
        addr[inst]  = $urandom;
        wdata[inst] = $urandom;
      end
      #1 checkOutput({nm, $sformatf("_stall_c%0d", k)}, 32'(stall[inst]), (k < lat) ? 32'd1 : 32'd0);
    end
  endtask

  // Monitor for instance 0
  always @(negedge clk) begin : mon0
    exp_t e;
    if (ack[0] === 1'b1) begin
      if (expQ0.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected_ack0: got ack at cycle %0d, expected none", cycleCnt);
      end else begin
        e = expQ0.pop_front();
        checkOutput({e.name, "_rdata"}, rdata[0], e.rdata);
        checkOutput({e.name, "_err"}, 32'(err[0]), 32'(e.err));
        checkOutput({e.name, "_ack_cycle"}, 32'(cycleCnt), 32'(e.due));
      end
    end
  end

  // Monitor for instance 1
  always @(negedge clk) begin : mon1
    exp_t e;
    if (ack[1] === 1'b1) begin
      if (expQ1.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected_ack1: got ack at cycle %0d, expected none", cycleCnt);
      end else begin
        e = expQ1.pop_front();
        checkOutput({e.name, "_rdata"}, rdata[1], e.rdata);
        checkOutput({e.name, "_err"}, 32'(err[1]), 32'(e.err));
        checkOutput({e.name, "_ack_cycle"}, 32'(cycleCnt), 32'(e.due));
      end
    end
  end

  // Hang guard
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i]   = 1'b0;
      we[i]    = 1'b0;
      addr[i]  = '0;
      wdata[i] = '0;
    end
    idleCycles(3);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset%0d_ack", i), 32'(ack[i]), 32'd0);
      checkOutput($sformatf("reset%0d_err", i), 32'(err[i]), 32'd0);
      checkOutput($sformatf("reset%0d_rdata", i), rdata[i], 32'd0);
      checkOutput($sformatf("reset%0d_stall", i), 32'(stall[i]), 32'd0);
    end
    rst = 1'b1;
    idleCycles(1);

    $display("[TB] instance 0: store/load, faults, last word");
    applyStimulus(0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, "st40", 0, 0, 0);
    idleCycles(1);
    applyStimulus(0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, "ld40", 0, 0, 0);
    idleCycles(1);
    applyStimulus(0, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1, "ld42_misal", 0, 0, 0);
    idleCycles(1);
    applyStimulus(0, 1'b1, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, "st0", 0, 0, 0);
    idleCycles(1);
    applyStimulus(0, 1'b1, 32'h1000, 32'hBADBAD00, 32'h0, 1'b1, "st_oor", 0, 0, 0);
    idleCycles(1);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, "ld0", 0, 0, 0);
    idleCycles(1);
    applyStimulus(0, 1'b0, 32'h80000040, 32'h0, 32'h0, 1'b1, "ld_high", 0, 0, 0);
    idleCycles(1);
    applyStimulus(0, 1'b1, 32'hFFC, 32'h0F0F0F0F, 32'h0, 1'b0, "st_last", 0, 0, 0);
    idleCycles(1);
    applyStimulus(0, 1'b0, 32'hFFC, 32'h0, 32'h0F0F0F0F, 1'b0, "ld_last", 0, 0, 0);
    idleCycles(1);

    $display("[TB] instance 0: back-to-back with req held across RESP");
    applyStimulus(0, 1'b1, 32'h44, 32'h55AA55AA, 32'h0, 1'b0, "b2b_st44", 1, 0, 0);
    applyStimulus(0, 1'b0, 32'h44, 32'h0, 32'h55AA55AA, 1'b0, "b2b_ld44", 0, 1, 0);
    idleCycles(1);

    $display("[TB] instance 0: reset in the middle of a store");
    applyStimulus(0, 1'b1, 32'h80, 32'h11111111, 32'h0, 1'b0, "st80", 0, 0, 0);
    idleCycles(1);
    applyStimulus(0, 1'b0, 32'h80, 32'h0, 32'h11111111, 1'b0, "ld80_pre", 0, 0, 0);
    idleCycles(1);
    req[0]   = 1'b1;
    we[0]    = 1'b1;
    addr[0]  = 32'h80;
    wdata[0] = 32'hAAAA5555;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_ack", 32'(ack[0]), 32'd0);
    checkOutput("midrst_err", 32'(err[0]), 32'd0);
    checkOutput("midrst_rdata", rdata[0], 32'd0);
    checkOutput("midrst_stall", 32'(stall[0]), 32'd0);
    applyStimulus(0, 1'b0, 32'h80, 32'h0, 32'h11111111, 1'b0, "ld80_post", 0, 0, 0);
    idleCycles(1);

    $display("[TB] instance 0: addr/wdata perturbed during WAIT");
    applyStimulus(0, 1'b1, 32'h48, 32'h13572468, 32'h0, 1'b0, "pert_st48", 0, 0, 1);
    idleCycles(1);
    applyStimulus(0, 1'b0, 32'h48, 32'h0, 32'h13572468, 1'b0, "pert_ld48", 0, 0, 1);
    idleCycles(1);

    $display("[TB] instance 1: LATENCY 1");
    applyStimulus(1, 1'b1, 32'h0, 32'h12345678, 32'h0, 1'b0, "l1_st0", 0, 0, 0);
    idleCycles(1);
    applyStimulus(1, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0, "l1_ld0", 0, 0, 0);
    idleCycles(1);
    applyStimulus(1, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1, "l1_ld3_misal", 0, 0, 0);
    idleCycles(1);
    applyStimulus(1, 1'b1, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1, "l1_st_oor", 0, 0, 0);
    idleCycles(1);
    applyStimulus(1, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0, "l1_ld0_again", 0, 0, 0);
    idleCycles(1);
    applyStimulus(1, 1'b1, 32'h3C, 32'h89ABCDEF, 32'h0, 1'b0, "l1_st_last", 1, 0, 0);
    applyStimulus(1, 1'b0, 32'h3C, 32'h0, 32'h89ABCDEF, 1'b0, "l1_ld_last_b2b", 0, 1, 0);
    idleCycles(3);

    checkOutput("pending_q0", 32'(expQ0.size()), 32'd0);
    checkOutput("pending_q1", 32'(expQ1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
